// File: rtl/seq_detect_pkg.sv
// ---------------------------------------------------------------------------
// seq_detect_pkg
// Shared types and helpers for the programmable serial pattern detector.
//   state_t  : FSM encoding (UNCFG=0, HUNT=1, MATCH=2)
//   len_w()  : width of the pattern-length field for a given maximum length
//   sat_inc(): increment that sticks at a ceiling instead of wrapping
// ---------------------------------------------------------------------------
package seq_detect_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        HUNT  = 2'd1,
        MATCH = 2'd2
    } state_t;

    // Length field must hold the value PAT_W itself, hence the +1.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/seq_hist_match.sv
// ---------------------------------------------------------------------------
// seq_hist_match
// History shift register, fill counter and length-masked pattern compare.
// o_hit is combinational: it reflects the history *after* the current bit
// is shifted in, so the owner can register the match on the same edge.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clr        : clear history and fill (pattern load)
//   i_shift      : accept i_bit this cycle
//   i_bit        : serial data bit
//   i_overlap    : when 0, fill restarts after a hit
//   i_abandon    : drop the partial match (fill -> 0) when not shifting
//   i_pat, i_len : active pattern and its length
//   o_fill_nz    : fill counter is non-zero (only with SEQDET_TIMEOUT_EN)
//   o_hit        : accepted bit completes the pattern
// ---------------------------------------------------------------------------
module seq_hist_match
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic             i_bit,
    input  logic             i_overlap,
    input  logic             i_abandon,
    input  logic [PAT_W-1:0] i_pat,
    input  logic [LEN_W-1:0] i_len,
`ifdef SEQDET_TIMEOUT_EN
    output logic             o_fill_nz,
`endif
    output logic             o_hit
);

    // The oldest bit never takes part in a compare once shifted out, so only
    // PAT_W-1 bits are stored; the incoming bit completes the PAT_W window.
    logic [PAT_W-2:0] r_hist;
    logic [LEN_W-1:0] r_fill;

    logic [PAT_W-1:0] w_hist_next;
    logic [LEN_W-1:0] w_fill_next;
    logic [PAT_W-1:0] w_mask;

    assign w_hist_next = {r_hist, i_bit};
    assign w_fill_next = (r_fill >= i_len) ? i_len : r_fill + LEN_W'(1);

    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
            assign w_mask[gi] = (LEN_W'(gi) < i_len);
        end
    endgenerate

    assign o_hit = i_shift
                && (((w_hist_next ^ i_pat) & w_mask) == '0)
                && (w_fill_next == i_len);

`ifdef SEQDET_TIMEOUT_EN
    assign o_fill_nz = (r_fill != '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_hist <= w_hist_next[PAT_W-2:0];
            // Non-overlapping mode: bits of this match may not seed the next.
            r_fill <= (o_hit && !i_overlap) ? '0 : w_fill_next;
        end else if (i_abandon) begin
            r_fill <= '0;
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// ---------------------------------------------------------------------------
// seq_detect_prog
// Programmable serial pattern detector. A 1..PAT_W bit pattern is loaded at
// run time and matched against a valid-qualified bit stream, with run-time
// overlapping/non-overlapping selection and a saturating hit counter.
// Optional macro SEQDET_TIMEOUT_EN adds an idle-gap timeout that abandons a
// partial match after TIMEOUT_CYC enabled cycles without an accepted bit.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ena                 : low freezes all state (match/timeout drop to 0)
//   load, pat_in, len_in: pattern load strobe, pattern, length
//   overlap             : 1 = overlapping matches
//   bit_valid, bit_in   : serial stream
//   match               : one-cycle registered match pulse
//   state_o             : 0 UNCFG, 1 HUNT, 2 MATCH
//   hit_count           : saturating match count
//   timeout             : one-cycle gap-timeout pulse (0 without the macro)
// ---------------------------------------------------------------------------
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int PAT_W       = 8,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  load,
    input  logic [PAT_W-1:0]      pat_in,
    input  logic [$clog2(PAT_W):0] len_in,
    input  logic                  overlap,
    input  logic                  bit_valid,
    input  logic                  bit_in,
    output logic                  match,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      hit_count,
    output logic                  timeout
);

    localparam int          LEN_W   = len_w(PAT_W);
    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    state_t           r_state;
    logic             r_match;
    logic [CNT_W-1:0] r_hit_count;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;

    state_t           w_state_next;
    logic             w_match_next;
    logic [CNT_W-1:0] w_hit_count_next;
    logic [PAT_W-1:0] w_pat_next;
    logic [LEN_W-1:0] w_len_next;

    logic w_clr;
    logic w_shift;
    logic w_hit;
    logic w_len_ok;
    logic w_abandon;

    assign w_clr    = ena & load;
    // Load wins over a same-cycle bit; UNCFG ignores the stream entirely.
    assign w_shift  = ena & bit_valid & ~load & (r_state != UNCFG);
    assign w_len_ok = (len_in != '0) && (len_in <= LEN_W'(PAT_W));

`ifdef SEQDET_TIMEOUT_EN
    localparam int             GAP_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYC);

    logic [GAP_W-1:0] r_gap;
    logic             r_timeout;
    logic [GAP_W-1:0] w_gap_next;
    logic [GAP_W-1:0] w_gap_inc;
    logic             w_timeout_next;
    logic             w_fill_nz;

    // Counter sticks at the limit while nothing is partially matched, so a
    // long idle period with fill==0 never produces a pulse.
    assign w_gap_inc = (r_gap == GAP_MAX) ? r_gap : r_gap + GAP_W'(1);

    always_comb begin
        w_gap_next     = r_gap;
        w_timeout_next = 1'b0;
        w_abandon      = 1'b0;
        if (ena) begin
            if (load || w_shift) begin
                w_gap_next = '0;
            end else if (r_state != UNCFG) begin
                if ((w_gap_inc == GAP_MAX) && w_fill_nz) begin
                    w_abandon      = 1'b1;
                    w_timeout_next = 1'b1;
                    w_gap_next     = '0;
                end else begin
                    w_gap_next = w_gap_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_gap     <= w_gap_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_abandon = 1'b0;
    assign timeout   = 1'b0;
`endif

    seq_hist_match #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_hist (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_shift   (w_shift),
        .i_bit     (bit_in),
        .i_overlap (overlap),
        .i_abandon (w_abandon),
        .i_pat     (r_pat),
        .i_len     (r_len),
`ifdef SEQDET_TIMEOUT_EN
        .o_fill_nz (w_fill_nz),
`endif
        .o_hit     (w_hit)
    );

    always_comb begin
        w_state_next     = r_state;
        w_match_next     = 1'b0;
        w_hit_count_next = r_hit_count;
        w_pat_next       = r_pat;
        w_len_next       = r_len;
        if (!ena) begin
            w_match_next = 1'b0;
        end else if (load) begin
            w_hit_count_next = '0;
            if (w_len_ok) begin
                w_state_next = HUNT;
                w_pat_next   = pat_in;
                w_len_next   = len_in;
            end else begin
                w_state_next = UNCFG;
            end
        end else if (r_state != UNCFG) begin
            if (w_hit) begin
                w_state_next     = MATCH;
                w_match_next     = 1'b1;
                w_hit_count_next = CNT_W'(sat_inc(32'(r_hit_count), CNT_MAX));
            end else begin
                // MATCH only survives a cycle that produces another hit.
                w_state_next = HUNT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= UNCFG;
            r_match     <= 1'b0;
            r_hit_count <= '0;
            r_pat       <= '0;
            r_len       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_match     <= w_match_next;
            r_hit_count <= w_hit_count_next;
            r_pat       <= w_pat_next;
            r_len       <= w_len_next;
        end
    end

    assign match     = r_match;
    assign state_o   = r_state;
    assign hit_count = r_hit_count;

endmodule

// File: tb/tb_seq_detect_prog.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_prog
// Directed bench for seq_detect_prog. Two instances share all inputs:
// dut_a (CNT_W=8) and dut_b (CNT_W=2, for counter saturation). Inputs change
// on the falling edge; outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_seq_detect_prog;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       load;
    logic [7:0] pat_in;
    logic [3:0] len_in;
    logic       overlap;
    logic       bit_valid;
    logic       bit_in;

    logic       match_a, match_b;
    logic [1:0] state_a, state_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       tmo_a, tmo_b;

    int checks   = 0;
    int failures = 0;

    seq_detect_prog #(.PAT_W(8), .CNT_W(8), .TIMEOUT_CYC(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .pat_in(pat_in),
        .len_in(len_in), .overlap(overlap), .bit_valid(bit_valid), .bit_in(bit_in),
        .match(match_a), .state_o(state_a), .hit_count(cnt_a), .timeout(tmo_a)
    );

    seq_detect_prog #(.PAT_W(8), .CNT_W(2), .TIMEOUT_CYC(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .pat_in(pat_in),
        .len_in(len_in), .overlap(overlap), .bit_valid(bit_valid), .bit_in(bit_in),
        .match(match_b), .state_o(state_b), .hit_count(cnt_b), .timeout(tmo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply load/bit_valid/bit_in at the falling edge, return just
    // after the following rising edge.
    task automatic step(input logic l, input logic v, input logic b);
        @(negedge clk);
        load      = l;
        bit_valid = v;
        bit_in    = b;
        @(posedge clk);
        #1;
        $display("step load=%0b valid=%0b bit=%0b -> match=%0b state=%0d cnt=%0d tmo=%0b",
                 l, v, b, match_a, state_a, cnt_a, tmo_a);
    endtask

    task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic ov);
        pat_in  = p;
        len_in  = l;
        overlap = ov;
        step(1'b1, 1'b0, 1'b0);
    endtask

    logic [6:0] stream;
    logic [6:0] exp_m2;
    logic [6:0] exp_m3;

    initial begin
        rst_n = 1'b0; ena = 1'b1; load = 1'b0; pat_in = '0; len_in = '0;
        overlap = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_state", 32'(state_a), 32'd0);
        check("rst_match", 32'(match_a), 32'd0);
        check("rst_cnt",   32'(cnt_a),   32'd0);
        check("rst_tmo",   32'(tmo_a),   32'd0);

        // 1: stream without a loaded pattern is ignored
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1);
            check("uncfg_match", 32'(match_a), 32'd0);
            check("uncfg_state", 32'(state_a), 32'd0);
        end
        check("uncfg_cnt", 32'(cnt_a), 32'd0);

        // 2: pattern 1011, overlapping; stream 1,0,1,1,0,1,1 (bit 0 first)
        stream = 7'b1101101;
        exp_m2 = 7'b1001000;
        exp_m3 = 7'b0001000;
        do_load(8'b0000_1011, 4'd4, 1'b1);
        check("load_state", 32'(state_a), 32'd1);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, stream[i]);
            check("ovl_match", 32'(match_a), 32'(exp_m2[i]));
            check("ovl_state", 32'(state_a), exp_m2[i] ? 32'd2 : 32'd1);
        end
        check("ovl_cnt",   32'(cnt_a), 32'd2);
        check("ovl_cnt_b", 32'(cnt_b), 32'd2);

        // 3: same pattern, non-overlapping
        do_load(8'b0000_1011, 4'd4, 1'b0);
        check("reload_cnt", 32'(cnt_a), 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, stream[i]);
            check("novl_match", 32'(match_a), 32'(exp_m3[i]));
        end
        check("novl_cnt", 32'(cnt_a), 32'd1);

        // 4: length-1 pattern, back-to-back matches
        do_load(8'b0000_0001, 4'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            check("len1_match", 32'(match_a), 32'd1);
            check("len1_state", 32'(state_a), 32'd2);
        end
        check("len1_cnt", 32'(cnt_a), 32'd3);
        step(1'b0, 1'b0, 1'b0);
        check("idle_match", 32'(match_a), 32'd0);
        check("idle_state", 32'(state_a), 32'd1);
        do_load(8'b0000_0001, 4'd0, 1'b1);
        check("len0_state", 32'(state_a), 32'd0);
        check("len0_cnt",   32'(cnt_a),   32'd0);
        do_load(8'b0000_0001, 4'd9, 1'b1);
        check("len9_state", 32'(state_a), 32'd0);

        // 5: saturation on the 2-bit counter
        do_load(8'b0000_0001, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
        check("sat_cnt_b", 32'(cnt_b), 32'd3);
        check("sat_cnt_a", 32'(cnt_a), 32'd5);

        // load with a same-cycle bit: the bit must not enter history
        pat_in = 8'b0000_0011; len_in = 4'd2; overlap = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        check("ldbit_state", 32'(state_a), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        check("ldbit_nomatch", 32'(match_a), 32'd0);
        step(1'b0, 1'b1, 1'b1);
        check("ldbit_match", 32'(match_a), 32'd1);

        // ena low freezes everything and suppresses match
        ena = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        check("ena0_match", 32'(match_a), 32'd0);
        check("ena0_cnt",   32'(cnt_a),   32'd1);
        ena = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        check("ena1_match", 32'(match_a), 32'd1);
        check("ena1_cnt",   32'(cnt_a),   32'd2);

        // 6: gap timeout (pattern 1011, send 1,0,1, idle 4, then 1)
        do_load(8'b0000_1011, 4'd4, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0);
`ifdef SEQDET_TIMEOUT_EN
            check("gap_tmo", 32'(tmo_a), (i == 3) ? 32'd1 : 32'd0);
`else
            check("gap_tmo", 32'(tmo_a), 32'd0);
`endif
        end
        step(1'b0, 1'b1, 1'b1);
        check("gap_tmo_end", 32'(tmo_a), 32'd0);
`ifdef SEQDET_TIMEOUT_EN
        check("gap_match", 32'(match_a), 32'd0);
`else
        check("gap_match", 32'(match_a), 32'd1);
`endif

        // asynchronous reset mid-operation
        do_load(8'b0000_0001, 4'd1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("pre_rst_match", 32'(match_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state_a), 32'd0);
        check("arst_cnt",   32'(cnt_a),   32'd0);
        check("arst_match", 32'(match_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        check("post_rst_match", 32'(match_a), 32'd0);
        check("post_rst_state", 32'(state_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
